rd_fwft_stage: RTL
==================

RD_FWFT_STAGE -- requirements
Module: rd_fwft_stage

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits.
REQ-002 rd_clk  input  1  read-domain clock; all state updates on rising edge.
REQ-003 rd_rst  input  1  reset, asynchronous, active-high.
REQ-004 fifo_empty  input  1  registered empty flag from the async FIFO read-pointer block.
REQ-005 fifo_rd_en  output  1  pop request to the read-pointer block; one word popped per cycle asserted.
REQ-006 fifo_rdata  input  DSIZE  FIFO memory read data, valid exactly one cycle after an accepted pop (registered-read RAM).
REQ-007 m_valid  output  1  output word valid (first-word-fall-through stream).
REQ-008 m_ready  input  1  downstream accepts m_data when m_valid && m_ready.
REQ-009 m_data  output  DSIZE  output word.
REQ-010 level  output  2  words held plus in flight, 0..2; present only with RD_FWFT_LEVEL_EN.

Function
REQ-011 Block SHALL hold three state items: inflight flag (pop issued last cycle), output register (head), skid register (second word).
REQ-012 pop = m_valid && m_ready; cnt = held words (0..2) + inflight (0/1).
REQ-013 fifo_rd_en SHALL equal !fifo_empty && !rd_rst && (cnt - pop) < 2, combinational.
REQ-014 inflight SHALL register fifo_rd_en each cycle.
REQ-015 Arriving word (inflight=1) SHALL go to output register if head empty or being popped with skid empty; otherwise to skid register.
REQ-016 On pop with skid full, skid word SHALL move to output register the same edge; arriving word then loads skid.
REQ-017 Word order SHALL be preserved exactly; no word dropped or duplicated.
REQ-018 m_data and m_valid SHALL be driven from registers only; m_data SHALL hold stable while m_valid && !m_ready.
REQ-019 Latency: fifo_empty low sampled in cycle N with cnt=0 -> fifo_rd_en=1 in N, m_valid=1 in N+2.
REQ-020 Throughput: with fifo_empty=0 and m_ready=1 continuously, one word per cycle after initial latency.
REQ-021 m_ready low: block SHALL stop issuing once cnt reaches 2; never more than 2 words stored or in flight.
REQ-022 fifo_empty asserting with in-flight pop: in-flight word SHALL still be captured and delivered.
REQ-023 Simultaneous pop and arrival with one word held: occupancy SHALL remain 1, new word at head.

Reset
REQ-024 rd_rst high SHALL clear inflight, skid valid, m_valid to 0 and force fifo_rd_en to 0 immediately.
REQ-025 m_data and skid data SHALL reset to 0.
REQ-026 Reset mid-operation SHALL discard held and in-flight words; first post-reset output is the next word popped after release.

Configuration
REQ-027 Macro RD_FWFT_LEVEL_EN defined: level port present, equals cnt registered view (held + inflight), reset 0.
REQ-028 Macro RD_FWFT_LEVEL_EN undefined: level port and its logic absent; all other behaviour identical.

Verification
REQ-029 FIFO holds 0x11,0x22,0x33, m_ready=1 -> fifo_rd_en 3 consecutive cycles, m_data 0x11,0x22,0x33 on consecutive cycles, first 2 cycles after first pop.
REQ-030 5 words queued, m_ready=0 -> exactly 2 pops issued, m_valid=1, m_data=first word stable, level=2; raise m_ready -> remaining 3 words follow, in order, no gaps.
REQ-031 m_ready toggling 1,0,1,0 over 8-word stream 0x01..0x08 -> all 8 delivered in order, no duplicates.
REQ-032 fifo_empty rises the cycle after a pop -> in-flight word delivered, then m_valid=0, fifo_rd_en=0.
REQ-033 rd_rst asserted with 2 words held -> m_valid=0, fifo_rd_en=0 same cycle, level=0; after release next FIFO word 0xA5 appears as first output.

Source files
------------

// File: rtl/rd_fwft_if.sv
// rtl/rd_fwft_if.sv - FIFO-read and output-stream bundle for rd_fwft_stage
// Signals:
//   fifo_empty  FIFO -> stage   registered empty flag from the read-pointer block
//   fifo_rd_en  stage -> FIFO   pop request, one word per asserted cycle
//   fifo_rdata  FIFO -> stage   read data, valid one cycle after an accepted pop
//   m_valid     stage -> sink   output word valid
//   m_ready     sink -> stage   downstream accept
//   m_data      stage -> sink   output word
//   level       stage -> sink   held + in-flight words (only with RD_FWFT_LEVEL_EN)
// modport master: the stage side; modport slave: the FIFO/sink environment.
interface rd_fwft_if #(
    parameter int DSIZE = 8
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [DSIZE-1:0] fifo_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
`ifdef RD_FWFT_LEVEL_EN
    logic [1:0]       level;

    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_rd_en, m_valid, m_data, level
    );
    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_rd_en, m_valid, m_data, level
    );
`else
    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_rd_en, m_valid, m_data
    );
    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
`endif
endinterface

// File: rtl/rd_fwft_stage.sv
// rtl/rd_fwft_stage.sv - first-word-fall-through output stage for a registered-read async FIFO
// Ports:
//   rd_clk  read-domain clock, rising edge
//   rd_rst  asynchronous active-high reset
//   rd_if   rd_fwft_if.master: FIFO pop/read-data side and valid/ready output stream
// Optional feature: define RD_FWFT_LEVEL_EN to expose rd_if.level (held + in-flight count).
module rd_fwft_stage #(
    parameter int DSIZE = 8
) (
    input  logic      rd_clk,
    input  logic      rd_rst,
    rd_fwft_if.master rd_if
);
    logic             inflight_q;
    logic             head_vld_q, head_vld_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic             skid_vld_q, skid_vld_d;
    logic [DSIZE-1:0] skid_q, skid_d;

    logic             pop;
    logic [1:0]       cnt;
    logic [1:0]       cnt_after_pop;
    logic             rd_en;

    assign pop = head_vld_q && rd_if.m_ready;

    // The issue rule below keeps cnt within 0..2, so two bits suffice.
    assign cnt = {1'b0, head_vld_q} + {1'b0, skid_vld_q} + {1'b0, inflight_q};
    // pop implies head_vld_q, so this never underflows.
    assign cnt_after_pop = cnt - {1'b0, pop};

    // Only issue when the word can still be stored after this cycle's pop.
    assign rd_en = !rd_if.fifo_empty && !rd_rst && (cnt_after_pop < 2'd2);

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (pop && skid_vld_q) begin
            // Skid advances to head; an arriving word refills skid behind it.
            head_d = skid_q;
            if (inflight_q) begin
                skid_d = rd_if.fifo_rdata;
            end else begin
                skid_vld_d = 1'b0;
            end
        end else if (inflight_q) begin
            if (!head_vld_q || pop) begin
                head_d     = rd_if.fifo_rdata;
                head_vld_d = 1'b1;
            end else begin
                skid_d     = rd_if.fifo_rdata;
                skid_vld_d = 1'b1;
            end
        end else if (pop) begin
            head_vld_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            inflight_q <= 1'b0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
        end else begin
            inflight_q <= rd_en;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
        end
    end

    assign rd_if.fifo_rd_en = rd_en;
    assign rd_if.m_valid    = head_vld_q;
    assign rd_if.m_data     = head_q;

`ifdef RD_FWFT_LEVEL_EN
    // Built purely from registered flags, so it is a registered view of cnt.
    assign rd_if.level = cnt;
`endif

endmodule
